// File: rtl/sync_debounce_multi.sv
// Multi-channel input conditioner: per channel a STAGES-deep synchronizer,
// a consecutive-sample debounce filter and registered rise/fall pulses.
// Each channel is an independent lane instance; any_rise is registered so
// it lines up with the per-lane rise pulses.

module sync_debounce_lane #(
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic async_in,
  output logic synced,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_nxt
);
  // DEBOUNCE_CYCLES=1 still needs a 1-bit counter; it only ever holds 0.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt;
  logic              differ;
  logic              done;
  logic              fall_nxt;

  assign synced   = sync_q[STAGES-1];
  assign differ   = (synced != stable);
  // The sample that completes the run flips stable and fires the pulse together.
  assign done     = enable && differ && (cnt == CNT_MAX);
  assign rise_nxt = done &  synced;
  assign fall_nxt = done & ~synced;

  // Synchronizer shift chain; runs regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], async_in};
  end

  // Debounce counter and filtered level; any disagreement-free sample or a
  // dropped enable throws away the partial run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= RESET_VAL;
    end else if (!enable || !differ) begin
      cnt    <= '0;
    end else if (done) begin
      cnt    <= '0;
      stable <= synced;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  // Edge pulses, registered so they coincide with the new stable value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end
endmodule

module sync_debounce_multi #(
  parameter int                  CHANNELS        = 4,
  parameter int                  STAGES          = 2,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0] RESET_VAL       = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] synced,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_rise
);
  logic [CHANNELS-1:0] rise_nxt;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    sync_debounce_lane #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VAL[g])
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .async_in (async_in[g]),
      .synced   (synced[g]),
      .stable   (stable[g]),
      .rise     (rise[g]),
      .fall     (fall[g]),
      .rise_nxt (rise_nxt[g])
    );
  end

  // Registered OR of next-cycle rise pulses, so it is coincident with rise[].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) any_rise <= 1'b0;
    else        any_rise <= |rise_nxt;
  end
endmodule

// File: tb/tb_sync_debounce_multi.sv
// Directed vector bench for sync_debounce_multi with CHANNELS=4, STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_VAL=0. Each vector is applied just after a rising
// edge and its expected outputs are checked just after the following edge.

module tb_sync_debounce_multi;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] async_in = 4'b0000;
  logic [3:0] synced, stable, rise, fall;
  logic       any_rise;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit       rst;
    bit       en;
    bit [3:0] a;
    bit [3:0] syn;
    bit [3:0] stb;
    bit [3:0] r;
    bit [3:0] f;
    bit       any;
  } vec_t;

  vec_t vecs[$];

  sync_debounce_multi #(
    .CHANNELS        (4),
    .STAGES          (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VAL       (4'b0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .async_in (async_in),
    .synced   (synced),
    .stable   (stable),
    .rise     (rise),
    .fall     (fall),
    .any_rise (any_rise)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input bit rst, input bit en, input bit [3:0] a,
                     input bit [3:0] syn, input bit [3:0] stb, input bit [3:0] r,
                     input bit [3:0] f, input bit any);
    vec_t v;
    v.rst = rst; v.en = en; v.a = a; v.syn = syn; v.stb = stb;
    v.r = r; v.f = f; v.any = any;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input bit [16:0] act, input bit [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got syn=%b stb=%b rise=%b fall=%b any=%b, want syn=%b stb=%b rise=%b fall=%b any=%b",
               name, act[16:13], act[12:9], act[8:5], act[4:1], act[0],
               exp[16:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  function automatic bit [16:0] outs();
    return {synced, stable, rise, fall, any_rise};
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      reset    = vecs[i].rst;
      enable   = vecs[i].en;
      async_in = vecs[i].a;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].syn, vecs[i].stb, vecs[i].r, vecs[i].f, vecs[i].any});
    end
  endtask

  initial begin
    //   n  rst en async  synced  stable  rise    fall    any
    // 0-1: held in reset with all inputs high
    add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    // 2-8: release; stable rises on the 6th edge, no pulse at release
    add(1, 1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    add(4, 1, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1);
    add(1, 1, 1, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0);
    // 9-15: all channels back to 0
    add(1, 1, 1, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0);
    add(4, 1, 1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 0);
    add(1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    // 16-22: ch0 rises
    add(1, 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    add(4, 1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
    add(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // 23-29: ch1 glitch, synced high 3 cycles, rejected
    add(1, 1, 1, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(2, 1, 1, 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 0);
    add(3, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // 30-36: ch2 rises to set up the fall test
    add(1, 1, 1, 4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(4, 1, 1, 4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0000, 1);
    add(1, 1, 1, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0);
    // 37-46: ch2 falls; enable dropped at count 2 restarts the run
    add(1, 1, 1, 4'b0001, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0);
    add(3, 1, 1, 4'b0001, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 0);
    add(1, 1, 0, 4'b0001, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 0);
    add(3, 1, 1, 4'b0001, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 0);
    add(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // 47-53: ch0 falls while ch3 rises on the same edge
    add(1, 1, 1, 4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(4, 1, 1, 4'b1000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 1);
    add(1, 1, 1, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0);
    // 54-60: ch0 rises while ch3 falls
    add(1, 1, 1, 4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 0);
    add(4, 1, 1, 4'b0001, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 1);
    add(1, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // 61-63: ch1 starts counting, reset follows mid-count
    add(1, 1, 1, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(2, 1, 1, 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 0);
    // 64-70: after release a fresh 6-edge latency is required
    add(1, 1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    add(4, 1, 1, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1, 1, 1, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 1);
    add(1, 1, 1, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 0);

    #2;
    check("reset_state", outs(), 17'd0);
    run_vecs(0, 63);

    // Asynchronous reset mid-count: outputs clear before any clock edge.
    reset = 1'b0;
    #1;
    check("async_reset_now", outs(), 17'd0);
    @(posedge clk); #1;
    check("async_reset_held", outs(), 17'd0);

    run_vecs(64, vecs.size() - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, got no finish, want finish");
    $fatal(1, "timeout");
  end
endmodule
